// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared types and widths for the MIPS issue arbiter
package mips_pkg;

    localparam int INSTR_W = 32;
    localparam int OREG_W  = 20;
    localparam int OUT_W   = 128;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        HALT  = 2'd2
    } arb_state_e;

    typedef struct packed {
        logic vld;
        logic owner;
    } tag_t;

endpackage

// File: rtl/mips_tag_pipe.sv
// rtl/mips_tag_pipe.sv - ownership tag delay line aligned to core latency, with in-flight count
module mips_tag_pipe
    import mips_pkg::*;
#(
    parameter int LAT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  tag_t issue_tag,
    input  logic push,
    output tag_t out_tag,
    output logic empty_next
);

    localparam int CNT_W = $clog2(LAT + 2);
    localparam logic [CNT_W-1:0] CNT_ONE = 1;

    // pipe[k] is entry k+1; entry 0 is the issue register itself
    tag_t             pipe [LAT];
    logic [CNT_W-1:0] inflight;
    logic [CNT_W-1:0] cnt_next;
    logic             retire;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LAT; i++) begin
                pipe[i] <= '0;
            end
        end else begin
            pipe[0] <= issue_tag;
            for (int i = 1; i < LAT; i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
    end

    assign out_tag = pipe[LAT-1];
    assign retire  = out_tag.vld;

    always_comb begin
        cnt_next = inflight;
        if (push && !retire) begin
            cnt_next = inflight + CNT_ONE;
        end else if (!push && retire) begin
            cnt_next = inflight - CNT_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight <= '0;
        end else begin
            inflight <= cnt_next;
        end
    end

    assign empty_next = (cnt_next == '0);

endmodule

// File: rtl/mips_issue_arbiter.sv
// rtl/mips_issue_arbiter.sv - two-port issue arbiter, result router and drain control for the MIPS core
// MIPS_ARB_FIXED_PRIO_EN: port 0 always wins contention (no round-robin pointer).
module mips_issue_arbiter
    import mips_pkg::*;
#(
    parameter int LAT = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [1:0]                   req_valid,
    input  logic [1:0][INSTR_W-1:0]      req_instr,
    input  logic [1:0][OREG_W-1:0]       req_oreg,
    output logic [1:0]                   req_ready,
    output logic                         mips_in_valid,
    output logic [INSTR_W-1:0]           mips_instruction,
    output logic [OREG_W-1:0]            mips_output_reg,
    input  logic                         mips_out_valid,
    input  logic [OUT_W-1:0]             mips_out,
    input  logic                         mips_fail,
    output logic [1:0]                   rsp_valid,
    output logic [OUT_W-1:0]             rsp_data,
    output logic                         rsp_fail,
    input  logic                         drain_req,
    output logic                         drain_done,
    output logic                         tag_err
);

    arb_state_e state, state_next;
    logic [1:0] grant;
    logic       issue_en;
    logic       accept;
    logic       issue_owner;
    tag_t       issue_tag;
    tag_t       out_tag;
    logic       empty_next;

`ifdef MIPS_ARB_FIXED_PRIO_EN
    always_comb begin
        grant = 2'b00;
        if (req_valid[0]) begin
            grant = 2'b01;
        end else if (req_valid[1]) begin
            grant = 2'b10;
        end
    end
`else
    // rr_last holds the port granted most recently; reset to 1 so port 0 wins first
    logic rr_last;

    always_comb begin
        grant = 2'b00;
        case (req_valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = rr_last ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_last <= 1'b1;
        end else if (accept) begin
            rr_last <= grant[1];
        end
    end
`endif

    assign req_ready = issue_en ? grant : 2'b00;
    assign accept    = |(req_valid & req_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mips_in_valid    <= 1'b0;
            issue_owner      <= 1'b0;
            mips_instruction <= '0;
            mips_output_reg  <= '0;
        end else begin
            mips_in_valid <= accept;
            issue_owner   <= accept & req_ready[1];
            if (accept) begin
                mips_instruction <= req_ready[1] ? req_instr[1] : req_instr[0];
                mips_output_reg  <= req_ready[1] ? req_oreg[1]  : req_oreg[0];
            end else begin
                mips_instruction <= '0;
                mips_output_reg  <= '0;
            end
        end
    end

    assign issue_tag = '{vld: mips_in_valid, owner: issue_owner};

    mips_tag_pipe #(
        .LAT (LAT)
    ) u_tag_pipe (
        .clk        (clk),
        .rst_n      (rst_n),
        .issue_tag  (issue_tag),
        .push       (accept),
        .out_tag    (out_tag),
        .empty_next (empty_next)
    );

    assign rsp_valid = (mips_out_valid && out_tag.vld) ? (out_tag.owner ? 2'b10 : 2'b01) : 2'b00;
    assign rsp_data  = mips_out;
    assign rsp_fail  = mips_fail;

    // any disagreement between core result strobe and expected tag is latched until reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_err <= 1'b0;
        end else if (mips_out_valid != out_tag.vld) begin
            tag_err <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        issue_en   = 1'b0;
        drain_done = 1'b0;
        case (state)
            RUN: begin
                issue_en = 1'b1;
                if (drain_req) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (empty_next) begin
                    state_next = HALT;
                end
            end
            HALT: begin
                drain_done = 1'b1;
                if (!drain_req) begin
                    state_next = RUN;
                end
            end
            default: state_next = RUN;
        endcase
    end

endmodule

// File: tb/tb_mips_issue_arbiter.sv
// tb/tb_mips_issue_arbiter.sv - randomized self-checking bench for mips_issue_arbiter
module tb_mips_issue_arbiter;

    localparam int LAT     = 4;
    localparam int M_RUN   = 0;
    localparam int M_DRAIN = 1;
    localparam int M_HALT  = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [1:0]        req_valid;
    logic [1:0][31:0]  req_instr;
    logic [1:0][19:0]  req_oreg;
    logic [1:0]        req_ready;
    logic              mips_in_valid;
    logic [31:0]       mips_instruction;
    logic [19:0]       mips_output_reg;
    logic              mips_out_valid;
    logic [127:0]      mips_out;
    logic              mips_fail;
    logic [1:0]        rsp_valid;
    logic [127:0]      rsp_data;
    logic              rsp_fail;
    logic              drain_req;
    logic              drain_done;
    logic              tag_err;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct {
        int           due;
        bit           owner;
        logic [127:0] data;
    } pend_t;

    pend_t        pend[$];
    int           m_state;
    bit           m_last;
    bit           m_iv;
    logic [31:0]  m_instr;
    logic [19:0]  m_oreg;
    bit           m_err;
    bit           core_mute;
    bit           cv[16];
    logic [127:0] cd[16];

    always #5 clk = ~clk;

    mips_issue_arbiter #(.LAT(LAT)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .req_valid        (req_valid),
        .req_instr        (req_instr),
        .req_oreg         (req_oreg),
        .req_ready        (req_ready),
        .mips_in_valid    (mips_in_valid),
        .mips_instruction (mips_instruction),
        .mips_output_reg  (mips_output_reg),
        .mips_out_valid   (mips_out_valid),
        .mips_out         (mips_out),
        .mips_fail        (mips_fail),
        .rsp_valid        (rsp_valid),
        .rsp_data         (rsp_data),
        .rsp_fail         (rsp_fail),
        .drain_req        (drain_req),
        .drain_done       (drain_done),
        .tag_err          (tag_err)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    function automatic logic [127:0] core_fn(input logic [31:0] i, input logic [19:0] o);
        return {i ^ 32'hA5A55A5A, 12'h000, o, ~i, i + {12'h000, o}};
    endfunction

    function automatic bit pick(input logic [1:0] v);
`ifdef MIPS_ARB_FIXED_PRIO_EN
        return !v[0];
`else
        if (v == 2'b11) return !m_last;
        return v[1] && !v[0];
`endif
    endfunction

    task automatic model_reset();
        pend.delete();
        m_state = M_RUN;
        m_last  = 1'b1;
        m_iv    = 1'b0;
        m_instr = '0;
        m_oreg  = '0;
        m_err   = 1'b0;
    endtask

    task automatic check_reset();
        check("rst_in_valid", mips_in_valid, 0);
        check("rst_instr", mips_instruction, 0);
        check("rst_oreg", mips_output_reg, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_drain_done", drain_done, 0);
        check("rst_tag_err", tag_err, 0);
    endtask

    // One clock: drive at posedge+1, check at negedge, then advance the reference model
    task automatic cycle(input logic [1:0] v, input logic [31:0] i0, input logic [31:0] i1,
                         input logic [19:0] o0, input logic [19:0] o1,
                         input logic dr, input logic inj, input logic rst);
        int         slot;
        bit         g;
        bit         acc;
        bit         tag_now;
        logic [1:0] exp_ready;
        logic [1:0] exp_rv;

        req_valid    = v;
        req_instr[0] = i0;
        req_instr[1] = i1;
        req_oreg[0]  = o0;
        req_oreg[1]  = o1;
        drain_req    = dr;
        slot           = cyc % 16;
        mips_out_valid = (cv[slot] && !core_mute) || inj;
        mips_out       = cd[slot];
        mips_fail      = 1'($urandom_range(0, 1));
        cv[slot]       = 1'b0;

        @(negedge clk);
        g         = pick(v);
        acc       = (m_state == M_RUN) && (v != 2'b00);
        exp_ready = acc ? (g ? 2'b10 : 2'b01) : 2'b00;
        tag_now   = (pend.size() > 0) && (pend[0].due == cyc);
        exp_rv    = (mips_out_valid && tag_now) ? (pend[0].owner ? 2'b10 : 2'b01) : 2'b00;

        check("req_ready", req_ready, exp_ready);
        check("in_valid", mips_in_valid, m_iv);
        check("instr", mips_instruction, m_instr);
        check("oreg", mips_output_reg, m_oreg);
        check("rsp_valid", rsp_valid, exp_rv);
        if (exp_rv != 2'b00) begin
            check("rsp_data", rsp_data, pend[0].data);
            check("rsp_fail", rsp_fail, mips_fail);
        end
        check("drain_done", drain_done, m_state == M_HALT);
        check("tag_err", tag_err, m_err);

        if (mips_in_valid) begin
            cv[(cyc + LAT) % 16] = 1'b1;
            cd[(cyc + LAT) % 16] = core_fn(mips_instruction, mips_output_reg);
        end

        if (rst) begin
            #1 rst_n = 1'b0;
            #1;
            check_reset();
            model_reset();
            g   = pick(v);
            acc = (v != 2'b00);
            #1 rst_n = 1'b1;
        end

        tag_now = (pend.size() > 0) && (pend[0].due == cyc);
        if (mips_out_valid != tag_now) m_err = 1'b1;
        if (tag_now) void'(pend.pop_front());
        if (acc) begin
            m_last  = g;
            m_iv    = 1'b1;
            m_instr = g ? i1 : i0;
            m_oreg  = g ? o1 : o0;
            pend.push_back('{due: cyc + 1 + LAT, owner: g, data: core_fn(m_instr, m_oreg)});
        end else begin
            m_iv    = 1'b0;
            m_instr = '0;
            m_oreg  = '0;
        end
        case (m_state)
            M_RUN:   if (dr) m_state = M_DRAIN;
            M_DRAIN: if (pend.size() == 0) m_state = M_HALT;
            M_HALT:  if (!dr) m_state = M_RUN;
            default: m_state = M_RUN;
        endcase

        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cycle(2'b00, '0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        logic dr;
        rst_n          = 1'b0;
        req_valid      = '0;
        req_instr      = '0;
        req_oreg       = '0;
        drain_req      = 1'b0;
        mips_out_valid = 1'b0;
        mips_out       = '0;
        mips_fail      = 1'b0;
        core_mute      = 1'b0;
        for (int k = 0; k < 16; k++) begin
            cv[k] = 1'b0;
            cd[k] = '0;
        end
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_reset();
        rst_n = 1'b1;

        cycle(2'b10, 32'h0, 32'h2021000A, 20'h0, 20'h00000, 1'b0, 1'b0, 1'b0);
        idle(LAT + 3);

        for (int k = 0; k < 4; k++)
            cycle(2'b11, 32'h1000 + k, 32'h2000 + k, 20'(k), 20'(16'h100 + k), 1'b0, 1'b0, 1'b0);
        idle(LAT + 3);

        for (int k = 0; k < 3; k++)
            cycle(2'b01, 32'h3000 + k, 32'h0, 20'(16'h300 + k), 20'h0, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < LAT + 5; k++)
            cycle(2'b11, $urandom, $urandom, 20'($urandom), 20'($urandom), 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++)
            cycle(2'b11, $urandom, $urandom, 20'($urandom), 20'($urandom), 1'b0, 1'b0, 1'b0);
        idle(LAT + 3);

        dr = 1'b0;
        for (int k = 0; k < 600; k++) begin
            if ($urandom_range(0, 24) == 0) dr = !dr;
            cycle(2'($urandom_range(0, 3)), $urandom, $urandom, 20'($urandom), 20'($urandom),
                  dr, 1'b0, 1'b0);
        end
        idle(LAT + 3);

        cycle(2'b00, '0, '0, '0, '0, 1'b0, 1'b1, 1'b0);
        idle(3);

        cycle(2'b00, '0, '0, '0, '0, 1'b0, 1'b0, 1'b1);
        cycle(2'b01, 32'h4444, '0, 20'h44, '0, 1'b0, 1'b0, 1'b0);
        core_mute = 1'b1;
        idle(LAT + 2);
        core_mute = 1'b0;

        cycle(2'b00, '0, '0, '0, '0, 1'b0, 1'b0, 1'b1);
        cycle(2'b01, 32'h5555, '0, 20'h55, '0, 1'b0, 1'b0, 1'b0);
        cycle(2'b10, '0, 32'h6666, '0, 20'h66, 1'b0, 1'b0, 1'b0);
        cycle(2'b00, '0, '0, '0, '0, 1'b0, 1'b0, 1'b1);
        idle(LAT + 4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
